// File: rtl/pio_echo_responder_pkg.sv
// pio_echo_pkg: opcodes, field positions and FSM states for the PIO echo responder
package pio_echo_pkg;
  localparam int REQ_BIT = 31;
  localparam int OP_MSB = 30;
  localparam int OP_LSB = 24;
  localparam int PAY_MSB = 23;
  localparam logic [6:0] OP_ECHO = 7'h00;
  localparam logic [6:0] OP_TS_LO = 7'h01;
  localparam logic [6:0] OP_TS_HI = 7'h02;
  localparam logic [6:0] OP_DELTA = 7'h03;
  localparam logic [6:0] OP_CLR = 7'h04;
  localparam logic [30:0] ERR_RESULT = 31'h7FFF_FFFF;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/pio_echo_responder_if.sv
// pio_echo_responder_if: HPS request/response PIO bundle
interface pio_echo_responder_if;
  logic [31:0] pio_out;
  logic [31:0] pio_in;
  logic busy;
  logic overrun;
  modport master (output pio_out, input pio_in, busy, overrun);
  modport slave (input pio_out, output pio_in, busy, overrun);
endinterface

// File: rtl/pio_echo_responder_cycle_counter.sv
// pio_cycle_counter: free-running wrapping cycle counter
module pio_cycle_counter #(
  parameter int CNT_W = 62
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + CNT_W'(1);
  assign cnt_o = cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pio_echo_responder.sv
// pio_echo_responder: answers toggle-signalled HPS PIO requests with echo/timestamp/delta results
module pio_echo_responder
  import pio_echo_pkg::*;
#(
  parameter int CNT_W = 62,
  parameter int RESP_DELAY = 0
) (
  input logic clk_clk,
  input logic reset_reset,
  pio_echo_responder_if.slave pio
);
  state_t state_q, state_d;
  logic [31:0] r_out_q, pio_in_q, pio_in_d;
  logic r_prev_q, req_seen_q, req_seen_d, busy_q, busy_d;
  logic overrun_q, overrun_d, prev_valid_q, prev_valid_d;
  logic [6:0] op_q, op_d;
  logic [23:0] pay_q, pay_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt, snap_q, snap_d, prev_snap_q, prev_snap_d, ts_hold_q, ts_hold_d, delta;
  logic [30:0] result;
  logic req_edge, ov_evt;
  pio_cycle_counter #(.CNT_W(CNT_W)) u_cnt (.clk_i(clk_clk), .rst_i(reset_reset), .cnt_o(cnt));
  assign req_edge = r_out_q[REQ_BIT] != req_seen_q;
  assign ov_evt = (r_out_q[REQ_BIT] != r_prev_q) && (state_q != IDLE);
  assign delta = snap_q - prev_snap_q;
  assign pio.pio_in = pio_in_q;
  assign pio.busy = busy_q;
  assign pio.overrun = overrun_q;
  always_comb begin
    result = ERR_RESULT;
    case (op_q)
      OP_ECHO:  result = {7'd0, pay_q};
      OP_TS_LO: result = snap_q[30:0];
      OP_TS_HI: result = 31'(ts_hold_q >> 31);
      OP_DELTA: result = !prev_valid_q ? '0 : (|delta[CNT_W-1:31]) ? ERR_RESULT : delta[30:0];
      OP_CLR:   result = '0;
      default:  result = ERR_RESULT;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    pay_d = pay_q;
    snap_d = snap_q;
    req_seen_d = req_seen_q;
    busy_d = busy_q;
    wcnt_d = wcnt_q;
    pio_in_d = pio_in_q;
    prev_snap_d = prev_snap_q;
    prev_valid_d = prev_valid_q;
    ts_hold_d = ts_hold_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: if (req_edge) begin
        op_d = r_out_q[OP_MSB:OP_LSB];
        pay_d = r_out_q[PAY_MSB:0];
        snap_d = cnt;
        req_seen_d = r_out_q[REQ_BIT];
        busy_d = 1'b1;
        wcnt_d = '0;
        state_d = (RESP_DELAY > 0) ? WAIT : RESP;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        state_d = (wcnt_q == 8'(RESP_DELAY - 1)) ? RESP : WAIT;
      end
      RESP: begin
        pio_in_d = {req_seen_q, result};
        busy_d = 1'b0;
        prev_snap_d = snap_q;
        prev_valid_d = 1'b1;
        ts_hold_d = (op_q == OP_TS_LO) ? snap_q : ts_hold_q;
        overrun_d = (op_q == OP_CLR) ? 1'b0 : overrun_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a new violation outranks a simultaneous clear
    if (ov_evt) overrun_d = 1'b1;
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state_q <= IDLE;
      r_out_q <= '0;
      r_prev_q <= 1'b0;
      req_seen_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      prev_valid_q <= 1'b0;
      op_q <= '0;
      pay_q <= '0;
      wcnt_q <= '0;
      pio_in_q <= '0;
      snap_q <= '0;
      prev_snap_q <= '0;
      ts_hold_q <= '0;
    end else begin
      state_q <= state_d;
      r_out_q <= pio.pio_out;
      r_prev_q <= r_out_q[REQ_BIT];
      req_seen_q <= req_seen_d;
      busy_q <= busy_d;
      overrun_q <= overrun_d;
      prev_valid_q <= prev_valid_d;
      op_q <= op_d;
      pay_q <= pay_d;
      wcnt_q <= wcnt_d;
      pio_in_q <= pio_in_d;
      snap_q <= snap_d;
      prev_snap_q <= prev_snap_d;
      ts_hold_q <= ts_hold_d;
    end
endmodule

// File: tb/tb_pio_echo_responder.sv
// tb_pio_echo_responder: directed vectors against three responders with delays 0, 3 and 10
module tb_pio_echo_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] po [3];
  logic [31:0] pi [3];
  logic bz [3];
  logic ov [3];
  int dly [3] = '{0, 3, 10};
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  pio_echo_responder_if ia ();
  pio_echo_responder_if ib ();
  pio_echo_responder_if ic ();
  assign ia.pio_out = po[0];
  assign ib.pio_out = po[1];
  assign ic.pio_out = po[2];
  assign pi[0] = ia.pio_in;
  assign pi[1] = ib.pio_in;
  assign pi[2] = ic.pio_in;
  assign bz[0] = ia.busy;
  assign bz[1] = ib.busy;
  assign bz[2] = ic.busy;
  assign ov[0] = ia.overrun;
  assign ov[1] = ib.overrun;
  assign ov[2] = ic.overrun;
  pio_echo_responder #(.CNT_W(62), .RESP_DELAY(0)) da (.clk_clk(clk), .reset_reset(rst), .pio(ia));
  pio_echo_responder #(.CNT_W(62), .RESP_DELAY(3)) db (.clk_clk(clk), .reset_reset(rst), .pio(ib));
  pio_echo_responder #(.CNT_W(62), .RESP_DELAY(10)) dc (.clk_clk(clk), .reset_reset(rst), .pio(ic));
  typedef struct {
    int k;
    bit set;
    logic [61:0] cval;
    logic [31:0] req;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [19];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // loads DUT a's counter; a request issued next sees snap = v + 1
  task automatic set_cnt(input logic [61:0] v);
    @(negedge clk);
    force da.u_cnt.cnt_d = v;
    @(posedge clk);
    #1 release da.u_cnt.cnt_d;
  endtask
  task automatic xact(input int k, input logic [31:0] req, input logic [31:0] exp, input string nm);
    logic [31:0] prev;
    @(negedge clk);
    prev = pi[k];
    po[k] = req;
    repeat (2 + dly[k]) @(posedge clk);
    @(negedge clk);
    chk({nm, " hold"}, pi[k], prev);
    @(posedge clk);
    @(negedge clk);
    chk(nm, pi[k], exp);
  endtask
  initial begin
    tv[0]  = '{2, 1'b0, 62'd0, 32'h8300_0000, 32'h8000_0000};
    tv[1]  = '{1, 1'b0, 62'd0, 32'h8000_0001, 32'h8000_0001};
    tv[2]  = '{1, 1'b0, 62'd0, 32'h00AB_CDEF, 32'h00AB_CDEF};
    tv[3]  = '{0, 1'b0, 62'd0, 32'h5500_0000, 32'h7FFF_FFFF};
    tv[4]  = '{0, 1'b0, 62'd0, 32'h8400_0000, 32'h8000_0000};
    tv[5]  = '{0, 1'b0, 62'd0, 32'h00FF_FFFF, 32'h00FF_FFFF};
    tv[6]  = '{1, 1'b0, 62'd0, 32'hFF00_0000, 32'hFFFF_FFFF};
    tv[7]  = '{2, 1'b0, 62'd0, 32'h0012_3456, 32'h0012_3456};
    tv[8]  = '{1, 1'b0, 62'd0, 32'h0500_0000, 32'h7FFF_FFFF};
    tv[9]  = '{0, 1'b1, 62'h3_7FFF_FFFD, 32'h8100_0000, 32'hFFFF_FFFE};
    tv[10] = '{0, 1'b0, 62'd0, 32'h0200_0000, 32'h0000_0006};
    tv[11] = '{0, 1'b1, 62'h3FFF_FFFF_FFFF_0000, 32'h8200_0000, 32'h8000_0006};
    tv[12] = '{0, 1'b1, 62'd1000, 32'h0000_0064, 32'h0000_0064};
    tv[13] = '{0, 1'b1, 62'd1100, 32'h8300_0000, 32'h8000_0064};
    tv[14] = '{0, 1'b1, 62'h3FFF_FFFF_FFFF_FFF5, 32'h0000_0001, 32'h0000_0001};
    tv[15] = '{0, 1'b1, 62'd39, 32'h8300_0000, 32'h8000_0032};
    tv[16] = '{0, 1'b1, 62'd0, 32'h0000_0002, 32'h0000_0002};
    tv[17] = '{0, 1'b1, 62'h8000_0000, 32'h8300_0000, 32'hFFFF_FFFF};
    tv[18] = '{0, 1'b1, 62'hFFFF_FFFE, 32'h0300_0000, 32'h7FFF_FFFE};
    for (int i = 0; i < 3; i++) po[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("rst pio_in%0d", i), pi[i], 32'h0);
    chk("rst busy", 32'(bz[0]), 32'h0);
    chk("rst overrun", 32'(ov[0]), 32'h0);
    // single-cycle busy and E2 latency on the zero-delay responder
    po[0] = 32'h8000_1234;
    @(posedge clk);
    @(negedge clk);
    chk("t1 busy E0", 32'(bz[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t1 busy E1", 32'(bz[0]), 32'h1);
    chk("t1 pio_in E1", pi[0], 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t1 busy E2", 32'(bz[0]), 32'h0);
    chk("t1 pio_in E2", pi[0], 32'h8000_1234);
    for (int i = 0; i < 19; i++) begin
      if (tv[i].set) set_cnt(tv[i].cval);
      xact(tv[i].k, tv[i].req, tv[i].exp, $sformatf("vec%0d", i));
    end
    // double toggle while busy: flag set, only the original request answered
    @(negedge clk);
    chk("t5 overrun pre", 32'(ov[2]), 32'h0);
    po[2] = 32'h8000_00AA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5 busy", 32'(bz[2]), 32'h1);
    po[2] = 32'h0000_00AA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5 overrun set", 32'(ov[2]), 32'h1);
    po[2] = 32'h8000_00AA;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("t5 response", pi[2], 32'h8000_00AA);
    chk("t5 busy done", 32'(bz[2]), 32'h0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t5 single response", pi[2], 32'h8000_00AA);
    chk("t5 overrun sticky", 32'(ov[2]), 32'h1);
    xact(2, 32'h0400_0000, 32'h0000_0000, "t5 clr");
    chk("t5 overrun cleared", 32'(ov[2]), 32'h0);
    xact(2, 32'hD500_0000, 32'hFFFF_FFFF, "t5 op55");
    // reset while waiting aborts without an ack
    @(negedge clk);
    po[2] = 32'h0000_BEEF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6 busy wait", 32'(bz[2]), 32'h1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) po[i] = '0;
    #1;
    chk("t6 pio_in async", pi[2], 32'h0);
    chk("t6 busy async", 32'(bz[2]), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6 no ack", pi[2], 32'h0);
    chk("t6 idle", 32'(bz[2]), 32'h0);
    xact(2, 32'h8000_BEEF, 32'h8000_BEEF, "t6 fresh");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
